// File: rtl/grf_pkg.sv
// Shared types and constants for the general register file and its commit-trace path.
package grf_pkg;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         NUM_REGS   = 32;
    localparam int         DROP_CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam trace_entry_t TRACE_ENTRY_ZERO = '{pc: 32'd0, addr: 5'd0, data: 32'd0};

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of commit-trace entries with sticky drop accounting.
module trace_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  trace_entry_t          push_data,
    input  logic                  pop_ready,
    output logic                  valid,
    output trace_entry_t          head,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic valid_s;
    logic full_s;
    logic pop_s;
    logic push_ok_s;
    logic drop_s;

    // Handshake decode; a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        valid_s   = (count_r != {CNT_W{1'b0}});
        full_s    = (count_r == CNT_W'(DEPTH));
        pop_s     = valid_s && pop_ready;
        push_ok_s = push && (!full_s || pop_s);
        drop_s    = push && full_s && !pop_s;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= TRACE_ENTRY_ZERO;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky drop flag and saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
            end
        end
    end

    assign valid    = valid_s;
    assign head     = mem_r[rd_ptr_r];
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: rtl/grf_wb_sink.sv
// 32x32 general register file fed by the write-back commit port, with W-to-D bypass and commit trace.
module grf_wb_sink
    import grf_pkg::*;
#(
    parameter int TRACE_DEPTH = 8,
    parameter bit LOG_ZERO    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  WD_RegWrite,
    input  logic [4:0]            WD_WRA,
    input  logic [31:0]           WD_WRD,
    input  logic [31:0]           WD_PCWhenWrite,
    input  logic [4:0]            D_RA1,
    input  logic [4:0]            D_RA2,
    output logic [31:0]           D_RD1,
    output logic [31:0]           D_RD2,
    output logic                  trc_valid,
    input  logic                  trc_ready,
    output logic [31:0]           trc_pc,
    output logic [4:0]            trc_addr,
    output logic [31:0]           trc_data,
    output logic                  trc_overflow,
    output logic [DROP_CNT_W-1:0] trc_drop_cnt
);

    logic [31:0]  regs_r [NUM_REGS];
    logic         wr_nz_s;
    logic         push_s;
    trace_entry_t push_entry_s;
    trace_entry_t head_s;

    // Commit decode: $0 is never written, and only logged when LOG_ZERO is set.
    always_comb begin
        wr_nz_s = WD_RegWrite && (WD_WRA != REG_ZERO);
        if (LOG_ZERO) begin
            push_s = WD_RegWrite;
        end else begin
            push_s = wr_nz_s;
        end
        push_entry_s = '{pc: WD_PCWhenWrite, addr: WD_WRA, data: WD_WRD};
    end

    // Register array update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_nz_s) begin
            regs_r[WD_WRA] <= WD_WRD;
        end
    end

    // Decode read ports: $0 reads zero, an in-flight commit to the same register bypasses the array.
    always_comb begin
        if (D_RA1 == REG_ZERO) begin
            D_RD1 = 32'd0;
        end else if (WD_RegWrite && (WD_WRA == D_RA1)) begin
            D_RD1 = WD_WRD;
        end else begin
            D_RD1 = regs_r[D_RA1];
        end
        if (D_RA2 == REG_ZERO) begin
            D_RD2 = 32'd0;
        end else if (WD_RegWrite && (WD_WRA == D_RA2)) begin
            D_RD2 = WD_WRD;
        end else begin
            D_RD2 = regs_r[D_RA2];
        end
    end

    trace_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop_ready (trc_ready),
        .valid     (trc_valid),
        .head      (head_s),
        .overflow  (trc_overflow),
        .drop_cnt  (trc_drop_cnt)
    );

    assign trc_pc   = head_s.pc;
    assign trc_addr = head_s.addr;
    assign trc_data = head_s.data;

endmodule

// File: tb/tb_grf_wb_sink.sv
// Directed bench for grf_wb_sink: bypass, $0 handling, trace overflow, full push/pop, async reset, back-to-back.
module tb_grf_wb_sink;

    logic        clk;
    logic        reset_n;
    logic        WD_RegWrite;
    logic [4:0]  WD_WRA;
    logic [31:0] WD_WRD;
    logic [31:0] WD_PCWhenWrite;
    logic [4:0]  D_RA1;
    logic [4:0]  D_RA2;
    logic        trc_ready;

    logic [31:0] rd1, rd2, tpc, tdata;
    logic [4:0]  taddr;
    logic        tvalid, tovf;
    logic [15:0] tdrop;

    logic [31:0] lz_rd1, lz_rd2, lz_pc, lz_data;
    logic [4:0]  lz_addr;
    logic        lz_valid, lz_ovf;
    logic [15:0] lz_drop;

    int checks   = 0;
    int failures = 0;

    grf_wb_sink #(.TRACE_DEPTH(8), .LOG_ZERO(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .WD_RegWrite(WD_RegWrite), .WD_WRA(WD_WRA),
        .WD_WRD(WD_WRD), .WD_PCWhenWrite(WD_PCWhenWrite), .D_RA1(D_RA1), .D_RA2(D_RA2),
        .D_RD1(rd1), .D_RD2(rd2), .trc_valid(tvalid), .trc_ready(trc_ready),
        .trc_pc(tpc), .trc_addr(taddr), .trc_data(tdata), .trc_overflow(tovf),
        .trc_drop_cnt(tdrop)
    );

    grf_wb_sink #(.TRACE_DEPTH(8), .LOG_ZERO(1'b1)) dut_lz (
        .clk(clk), .reset_n(reset_n), .WD_RegWrite(WD_RegWrite), .WD_WRA(WD_WRA),
        .WD_WRD(WD_WRD), .WD_PCWhenWrite(WD_PCWhenWrite), .D_RA1(D_RA1), .D_RA2(D_RA2),
        .D_RD1(lz_rd1), .D_RD2(lz_rd2), .trc_valid(lz_valid), .trc_ready(trc_ready),
        .trc_pc(lz_pc), .trc_addr(lz_addr), .trc_data(lz_data), .trc_overflow(lz_ovf),
        .trc_drop_cnt(lz_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        WD_RegWrite    = 1'b1;
        WD_WRA         = a;
        WD_WRD         = d;
        WD_PCWhenWrite = pc;
    endtask

    initial begin
        reset_n = 1'b0; WD_RegWrite = 1'b0; WD_WRA = 5'd0; WD_WRD = 32'd0;
        WD_PCWhenWrite = 32'd0; D_RA1 = 5'd5; D_RA2 = 5'd0; trc_ready = 1'b0;
        #1;
        check_val("rst_valid", {31'd0, tvalid}, 32'd0);
        check_val("rst_rd1", rd1, 32'd0);
        check_val("rst_drop", {16'd0, tdrop}, 32'd0);
        check_val("rst_ovf", {31'd0, tovf}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Bypass of $5 and trace latency
        commit(5'd5, 32'hDEADBEEF, 32'h00003000);
        #1;
        check_val("bypass_rd1", rd1, 32'hDEADBEEF);
        check_val("no_passthru", {31'd0, tvalid}, 32'd0);
        tick();
        WD_RegWrite = 1'b0;
        #1;
        check_val("reg5_rd1", rd1, 32'hDEADBEEF);
        check_val("t1_valid", {31'd0, tvalid}, 32'd1);
        check_val("t1_pc", tpc, 32'h00003000);
        check_val("t1_addr", {27'd0, taddr}, 32'd5);
        check_val("t1_data", tdata, 32'hDEADBEEF);
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
        #1;
        check_val("t1_empty", {31'd0, tvalid}, 32'd0);

        // $0 write: never stored, logged only with LOG_ZERO
        commit(5'd0, 32'h12345678, 32'h00003004);
        D_RA1 = 5'd0;
        #1;
        check_val("z_rd1_c0", rd1, 32'd0);
        check_val("z_lz_rd1_c0", lz_rd1, 32'd0);
        tick();
        WD_RegWrite = 1'b0;
        #1;
        check_val("z_rd1_c1", rd1, 32'd0);
        check_val("z_nolog", {31'd0, tvalid}, 32'd0);
        check_val("z_lz_valid", {31'd0, lz_valid}, 32'd1);
        check_val("z_lz_pc", lz_pc, 32'h00003004);
        check_val("z_lz_addr", {27'd0, lz_addr}, 32'd0);
        check_val("z_lz_data", lz_data, 32'h12345678);
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;

        // Overflow: 10 commits into 8 entries
        for (int i = 1; i <= 10; i++) begin
            commit(5'(i), 32'(i), 32'h100 + 32'(4 * i));
            tick();
        end
        WD_RegWrite = 1'b0;
        #1;
        check_val("ovf_drop", {16'd0, tdrop}, 32'd2);
        check_val("ovf_flag", {31'd0, tovf}, 32'd1);
        check_val("ovf_head_addr", {27'd0, taddr}, 32'd1);
        check_val("ovf_head_pc", tpc, 32'h00000104);

        // Full: simultaneous push and pop is accepted without a drop
        commit(5'd11, 32'd11, 32'h00000200);
        trc_ready = 1'b1;
        tick();
        WD_RegWrite = 1'b0;
        #1;
        check_val("pp_drop", {16'd0, tdrop}, 32'd2);
        for (int k = 2; k <= 9; k++) begin
            int exp_a;
            exp_a = (k == 9) ? 11 : k;
            check_val("drain_valid", {31'd0, tvalid}, 32'd1);
            check_val("drain_addr", {27'd0, taddr}, 32'(exp_a));
            check_val("drain_data", tdata, 32'(exp_a));
            tick();
        end
        check_val("drain_empty", {31'd0, tvalid}, 32'd0);
        D_RA1 = 5'd10; D_RA2 = 5'd11;
        #1;
        check_val("reg10", rd1, 32'd10);
        check_val("reg11", rd2, 32'd11);

        // Asynchronous reset with three entries queued
        trc_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            commit(5'(i), 32'hA0 + 32'(i), 32'h300 + 32'(4 * i));
            tick();
        end
        WD_RegWrite = 1'b0;
        trc_ready = 1'b1;
        D_RA1 = 5'd1; D_RA2 = 5'd10;
        #1;
        check_val("ar_pre_valid", {31'd0, tvalid}, 32'd1);
        check_val("ar_pre_rd1", rd1, 32'h000000A1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_valid", {31'd0, tvalid}, 32'd0);
        check_val("ar_rd1", rd1, 32'd0);
        check_val("ar_rd2", rd2, 32'd0);
        check_val("ar_ovf", {31'd0, tovf}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        check_val("ar_drop", {16'd0, tdrop}, 32'd0);
        check_val("ar_post_valid", {31'd0, tvalid}, 32'd0);

        // Back-to-back writes to $7 with a continuously ready consumer
        D_RA1 = 5'd7;
        commit(5'd7, 32'd1, 32'h400);
        #1;
        check_val("b2b_byp1", rd1, 32'd1);
        tick();
        commit(5'd7, 32'd2, 32'h404);
        #1;
        check_val("b2b_t1", tdata, 32'd1);
        check_val("b2b_byp2", rd1, 32'd2);
        tick();
        commit(5'd7, 32'd3, 32'h408);
        #1;
        check_val("b2b_t2", tdata, 32'd2);
        check_val("b2b_t2_valid", {31'd0, tvalid}, 32'd1);
        tick();
        WD_RegWrite = 1'b0;
        #1;
        check_val("b2b_t3", tdata, 32'd3);
        check_val("b2b_t3_pc", tpc, 32'h408);
        tick();
        check_val("b2b_empty", {31'd0, tvalid}, 32'd0);
        check_val("b2b_reg7", rd1, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
